switch_cfg_loader: RTL

SWITCH_CFG_LOADER -- requirements
Module: switch_cfg_loader

---
 rtl/switch_cfg_pkg.sv | 28 ++
 rtl/switch_cfg_word_check.sv | 36 +++
 rtl/switch_cfg_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/switch_cfg_pkg.sv
// Shared definitions for the serial switch-matrix configuration loader:
// side codes, frame sync byte, loader state encoding and word-count helper.
package switch_cfg_pkg;

  // Side codes carried in bits [2:0] of every config word
  localparam logic [2:0] SIDE_NONE   = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  localparam int unsigned SYNC_W    = 8;
  localparam int unsigned CSUM_W    = 8;
  localparam logic [7:0]  SYNC_WORD = 8'hA5;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CSUM  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  // Number of config words in a frame: one per pin on all four sides
  function automatic int unsigned calc_nw(input int unsigned ntb, input int unsigned nlr);
    return 2 * ntb + 2 * nlr;
  endfunction

endpackage

// File: rtl/switch_cfg_word_check.sv
// Combinational legality check of one config word.
// Ports: word  - config word, [WW-1:3] pin index, [2:0] side code
//        legal - 1 when side code is known and index fits that side
module switch_cfg_word_check
  import switch_cfg_pkg::*;
#(
  parameter int unsigned NTB = 5,
  parameter int unsigned NLR = 4,
  parameter int unsigned WW  = 6
) (
  input  logic [WW-1:0] word,
  output logic          legal
);

  localparam int unsigned IW = WW - 3;

  logic [2:0]    side;
  logic [IW-1:0] idx;
  logic [31:0]   idx_ext;

  assign side    = word[2:0];
  assign idx     = word[WW-1:3];
  assign idx_ext = 32'(idx);

  // Code 0 leaves the pin unconnected, so any index is acceptable
  always_comb begin
    legal = 1'b0;
    case (side)
      SIDE_NONE:              legal = 1'b1;
      SIDE_TOP, SIDE_BOTTOM:  legal = (idx_ext < 32'(NTB));
      SIDE_RIGHT, SIDE_LEFT:  legal = (idx_ext < 32'(NLR));
      default:                legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/switch_cfg_loader.sv
// Serial bitstream loader for the switch matrix. Hunts for the sync byte,
// shifts NW config words into a shadow copy while summing them, then checks
// the trailing checksum and word legality before committing the shadow.
// Ports: clk, rst_n            - clock, async active-low reset
//        cfg_valid, cfg_bit    - serial bit stream, MSB first
//        cfg_ready             - loader accepts a bit this cycle
//        cfg_active            - committed config, word k at [WW*k +: WW]
//        cfg_done / cfg_err    - one-cycle commit / reject pulses
module switch_cfg_loader
  import switch_cfg_pkg::*;
#(
  parameter int unsigned NTB = 5,
  parameter int unsigned NLR = 4,
  parameter int unsigned WW  = 6
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_valid,
  input  logic                                  cfg_bit,
  output logic                                  cfg_ready,
  output logic [WW*(2*NTB+2*NLR)-1:0]           cfg_active,
  output logic                                  cfg_done,
  output logic                                  cfg_err
);

  localparam int unsigned NW   = calc_nw(NTB, NLR);
  localparam int unsigned AW   = NW * WW;
  localparam int unsigned BMAX = (WW > CSUM_W) ? WW : CSUM_W;
  localparam int unsigned BCW  = $clog2(BMAX + 1);
  localparam int unsigned WCW  = $clog2(NW + 1);

  state_t             state;
  logic [SYNC_W-2:0]  sync_sr;
  logic [WW-2:0]      word_sr;
  logic [CSUM_W-1:0]  csum_sr;
  logic [CSUM_W-1:0]  sum;
  logic [BCW-1:0]     bit_cnt;
  logic [WCW-1:0]     word_cnt;
  logic [AW-1:0]      shadow;
  logic               illegal_seen;

  logic               xfer;
  logic [SYNC_W-1:0]  sync_nxt;
  logic [WW-1:0]      word_nxt;
  logic               word_legal;
  logic               frame_ok;

  assign xfer     = cfg_valid & cfg_ready;
  assign sync_nxt = {sync_sr, cfg_bit};
  assign word_nxt = {word_sr, cfg_bit};
  assign frame_ok = (csum_sr == sum) && !illegal_seen;

  switch_cfg_word_check #(
    .NTB (NTB),
    .NLR (NLR),
    .WW  (WW)
  ) u_word_check (
    .word  (word_nxt),
    .legal (word_legal)
  );

  // Loader FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_SYNC;
      sync_sr      <= '0;
      word_sr      <= '0;
      csum_sr      <= '0;
      sum          <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      shadow       <= '0;
      illegal_seen <= 1'b0;
      cfg_active   <= '0;
      cfg_ready    <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (xfer) begin
            // Cleared on match so the next frame needs a full fresh sync byte
            if (sync_nxt == SYNC_WORD) begin
              state        <= ST_LOAD;
              sync_sr      <= '0;
              bit_cnt      <= '0;
              word_cnt     <= '0;
              sum          <= '0;
              illegal_seen <= 1'b0;
            end else begin
              sync_sr <= sync_nxt[SYNC_W-2:0];
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            word_sr <= word_nxt[WW-2:0];
            if (bit_cnt == BCW'(WW - 1)) begin
              bit_cnt                    <= '0;
              shadow[word_cnt*WW +: WW]  <= word_nxt;
              sum                        <= sum + CSUM_W'(word_nxt);
              if (!word_legal) illegal_seen <= 1'b1;
              if (word_cnt == WCW'(NW - 1)) begin
                state    <= ST_CSUM;
                word_cnt <= '0;
              end else begin
                word_cnt <= word_cnt + WCW'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            csum_sr <= {csum_sr[CSUM_W-2:0], cfg_bit};
            if (bit_cnt == BCW'(CSUM_W - 1)) begin
              bit_cnt   <= '0;
              state     <= ST_CHECK;
              cfg_ready <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        ST_CHECK: begin
          if (frame_ok) begin
            cfg_active <= shadow;
            cfg_done   <= 1'b1;
          end else begin
            cfg_err <= 1'b1;
          end
          state <= ST_SYNC;
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule
